// File: rtl/router_fsm_mc_pkg.sv
// Shared types and helpers for the multi-channel router controller FSM.
package router_pkg;

  // Controller states. The encoding is fixed so illegal codes are easy to spot.
  typedef enum logic [3:0] {
    ST_DA   = 4'd0,
    ST_WTE  = 4'd1,
    ST_LFD  = 4'd2,
    ST_LD   = 4'd3,
    ST_FFS  = 4'd4,
    ST_LAF  = 4'd5,
    ST_LP   = 4'd6,
    ST_CPE  = 4'd7,
    ST_DROP = 4'd8
  } state_e;

  localparam int         MAX_LEN_DEF = 63;
  localparam int         LEN_W       = 8;
  localparam logic [7:0] LEN_SAT     = 8'd255;

  // Moore control outputs, one bit per decoded state flag.
  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
    logic wr_en_reg;
    logic busy;
    logic drop_pkt;
  } ctrl_t;

  // Smallest address width that can name every channel (at least 1 bit).
  function automatic int addr_w_for(input int num_ch);
    int w;
    w = 1;
    for (int i = 0; i < 5; i++) begin
      if ((1 << w) < num_ch) begin
        w = w + 1;
      end
    end
    return w;
  endfunction

  // Output decode for a state; unknown codes look like DA.
  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_DA:   c.detect_add = 1'b1;
      ST_WTE:  c.busy = 1'b1;
      ST_LFD:  begin c.lfd_state = 1'b1; c.wr_en_reg = 1'b1; c.busy = 1'b1; end
      ST_LD:   begin c.ld_state = 1'b1; c.wr_en_reg = 1'b1; end
      ST_FFS:  begin c.full_state = 1'b1; c.busy = 1'b1; end
      ST_LAF:  begin c.laf_state = 1'b1; c.wr_en_reg = 1'b1; c.busy = 1'b1; end
      ST_LP:   begin c.wr_en_reg = 1'b1; c.busy = 1'b1; end
      ST_CPE:  begin c.rst_int_reg = 1'b1; c.busy = 1'b1; end
      ST_DROP: c.drop_pkt = 1'b1;
      default: c.detect_add = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/router_fsm_mc_if.sv
// Input packet bus between the byte source and the router controller.
interface router_fsm_mc_if #(
  parameter int ADDR_W = 2
) ();
  logic              pkt_valid;
  logic [ADDR_W-1:0] d_in;
  logic              busy;

  modport master (output pkt_valid, output d_in, input busy);
  modport slave  (input pkt_valid, input d_in, output busy);
endinterface

// File: rtl/router_fsm_mc.sv
// Router controller FSM: steers one packet stream to NUM_CH output FIFOs,
// drops packets with an out-of-range address and flags over-length payloads.
module router_fsm_mc
  import router_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = addr_w_for(NUM_CH),
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  router_fsm_mc_if.slave    bus,
  input  logic [NUM_CH-1:0] fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_rst,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic [ADDR_W-1:0] dest,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              wr_en_reg,
  output logic              drop_pkt,
  output logic              len_err
);

  // Channel vectors are padded to the full address space so that any
  // address (including unused ones) indexes a defined zero bit.
  localparam int          NSEL      = 1 << ADDR_W;
  localparam logic [31:0] NUM_CH_U  = NUM_CH;
  localparam logic [7:0]  MAX_LEN_C = 8'(MAX_LEN);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
  logic               len_err_q, len_err_d;
  ctrl_t              ctrl_q;

  logic [NSEL-1:0]    full_pad, empty_pad, srst_pad;
  logic               full_sel, empty_sel, soft_sel, hdr_empty, hdr_legal;

  // Zero-extend the per-channel flags to the address space.
  always_comb begin
    full_pad  = '0;
    empty_pad = '0;
    srst_pad  = '0;
    full_pad[NUM_CH-1:0]  = fifo_full;
    empty_pad[NUM_CH-1:0] = fifo_empty;
    srst_pad[NUM_CH-1:0]  = soft_rst;
  end

  assign full_sel  = full_pad[dest_q];
  assign empty_sel = empty_pad[dest_q];
  assign soft_sel  = srst_pad[dest_q];
  assign hdr_empty = empty_pad[bus.d_in];
  assign hdr_legal = ({{(32-ADDR_W){1'b0}}, bus.d_in} < NUM_CH_U);

  // Next-state, destination latch and length tracking.
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    len_cnt_d = len_cnt_q;
    len_err_d = len_err_q;
    if (soft_sel && (state_q != ST_DA) && (state_q != ST_DROP)) begin
      // Channel flushed underneath us: abandon the packet, keep dest.
      state_d   = ST_DA;
      len_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_DA: begin
          if (bus.pkt_valid) begin
            dest_d    = bus.d_in;
            len_cnt_d = '0;
            if (!hdr_legal) begin
              state_d = ST_DROP;
            end else if (hdr_empty) begin
              state_d = ST_LFD;
            end else begin
              state_d = ST_WTE;
            end
          end else begin
            state_d = ST_DA;
          end
        end
        ST_WTE: begin
          if (empty_sel) begin
            state_d = ST_LFD;
          end else begin
            state_d = ST_WTE;
          end
        end
        ST_LFD: begin
          len_err_d = 1'b0;
          state_d   = ST_LD;
        end
        ST_LD: begin
          if (bus.pkt_valid) begin
            // Over-length bytes are still written; only the flag is raised.
            if (len_cnt_q == MAX_LEN_C) begin
              len_err_d = 1'b1;
            end else begin
              len_err_d = len_err_q;
            end
            if (len_cnt_q != LEN_SAT) begin
              len_cnt_d = len_cnt_q + 8'd1;
            end else begin
              len_cnt_d = len_cnt_q;
            end
          end else begin
            len_cnt_d = len_cnt_q;
          end
          if (full_sel) begin
            state_d = ST_FFS;
          end else if (!bus.pkt_valid) begin
            state_d = ST_LP;
          end else begin
            state_d = ST_LD;
          end
        end
        ST_FFS: begin
          if (!full_sel) begin
            state_d = ST_LAF;
          end else begin
            state_d = ST_FFS;
          end
        end
        ST_LAF: begin
          if (parity_done) begin
            state_d = ST_DA;
          end else if (low_pkt_valid) begin
            state_d = ST_LP;
          end else begin
            state_d = ST_LD;
          end
        end
        ST_LP:   state_d = ST_CPE;
        ST_CPE: begin
          if (full_sel) begin
            state_d = ST_FFS;
          end else begin
            state_d = ST_DA;
          end
        end
        ST_DROP: begin
          if (!bus.pkt_valid) begin
            state_d = ST_DA;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: state_d = ST_DA;
      endcase
    end
  end

  // State, data registers and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_DA;
      dest_q    <= '0;
      len_cnt_q <= '0;
      len_err_q <= 1'b0;
      ctrl_q    <= decode_state(ST_DA);
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      len_cnt_q <= len_cnt_d;
      len_err_q <= len_err_d;
      ctrl_q    <= decode_state(state_d);
    end
  end

  assign dest        = dest_q;
  assign len_err     = len_err_q;
  assign detect_add  = ctrl_q.detect_add;
  assign lfd_state   = ctrl_q.lfd_state;
  assign ld_state    = ctrl_q.ld_state;
  assign laf_state   = ctrl_q.laf_state;
  assign full_state  = ctrl_q.full_state;
  assign rst_int_reg = ctrl_q.rst_int_reg;
  assign wr_en_reg   = ctrl_q.wr_en_reg;
  assign bus.busy    = ctrl_q.busy;
  assign drop_pkt    = ctrl_q.drop_pkt;

endmodule
